sleep_gate_fsm_ctrl: RTL and testbench

//  Parametrised per-channel power-gating controller for the vga_lcd gated domains.

---
 rtl/sleep_gate_fsm_ctrl.sv | 89 ++++++++
 tb/tb_sleep_gate_fsm_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sleep_gate_fsm_ctrl.sv
// sleep_gate_fsm_ctrl: per-channel idle-debounced power-gating sequencer with dependency masks
module sleep_gate_fsm_ctrl #(
  parameter int                     N_CH        = 10,
  parameter int                     IDLE_CYCLES = 16,
  parameter int                     WAKE_CYCLES = 4,
  parameter int                     CNT_W       = 8,
  parameter logic [N_CH*N_CH-1:0]   DEP_MASK    = '0
) (
  input  logic            clk_i,
  input  logic            nrst_i,
  input  logic            gate_en_i,
  input  logic [N_CH-1:0] sensor_i,
  input  logic [N_CH-1:0] pwr_ok_i,
  output logic [N_CH-1:0] pwr_on_o,
  output logic [N_CH-1:0] iso_o,
  output logic [N_CH-1:0] sleep_o,
  output logic            busy_o
);
  typedef enum logic [2:0] {S_ON, S_ISO, S_OFF, S_WAKE, S_SETTLE} state_t;
  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  state_t           st_q  [N_CH];
  state_t           st_d  [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  idle, req, act, bsy, pwr_on_q, iso_q, sleep_q;
  logic             busy_q;
  always_comb
    for (int i = 0; i < N_CH; i++)
      idle[i] = (st_q[i] == S_ON && cnt_q[i] == IDLE_MAX) || st_q[i] == S_ISO || st_q[i] == S_OFF;
  always_comb
    for (int i = 0; i < N_CH; i++) begin
      act[i] = sensor_i[i] & gate_en_i;
      req[i] = gate_en_i & idle[i] & (&(idle | ~DEP_MASK[i*N_CH +: N_CH]));
    end
  always_comb
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        S_ON: begin
          st_d[i]  = req[i] ? S_ISO : S_ON;
          cnt_d[i] = (req[i] || !act[i]) ? '0 : (cnt_q[i] == IDLE_MAX ? cnt_q[i] : cnt_q[i] + 1'b1);
        end
        S_ISO:  st_d[i] = S_OFF;
        S_OFF:  st_d[i] = act[i] ? S_OFF : S_WAKE;
        S_WAKE: begin
          st_d[i]  = pwr_ok_i[i] ? S_SETTLE : S_WAKE;
          cnt_d[i] = '0;
        end
        S_SETTLE: begin
          st_d[i]  = cnt_q[i] == WAKE_LAST ? S_ON : S_SETTLE;
          cnt_d[i] = cnt_q[i] == WAKE_LAST ? '0 : cnt_q[i] + 1'b1;
        end
        default: begin
          st_d[i]  = S_ON;
          cnt_d[i] = '0;
        end
      endcase
    end
  always_comb
    for (int i = 0; i < N_CH; i++)
      bsy[i] = st_d[i] == S_ISO || st_d[i] == S_WAKE || st_d[i] == S_SETTLE;
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= S_ON;
        cnt_q[i] <= '0;
      end
      pwr_on_q <= '1;
      iso_q    <= '0;
      sleep_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]     <= st_d[i];
        cnt_q[i]    <= cnt_d[i];
        pwr_on_q[i] <= st_d[i] != S_OFF;
        iso_q[i]    <= st_d[i] != S_ON;
        sleep_q[i]  <= st_d[i] == S_OFF;
      end
      busy_q <= |bsy;
    end
  end
  assign pwr_on_o = pwr_on_q;
  assign iso_o    = iso_q;
  assign sleep_o  = sleep_q;
  assign busy_o   = busy_q;
endmodule

// File: tb/tb_sleep_gate_fsm_ctrl.sv
// tb_sleep_gate_fsm_ctrl: scoreboard bench against an event-level model of the gating sequence
module tb_sleep_gate_fsm_ctrl;
  localparam int N = 10;
  localparam int IDLE = 4;
  localparam int WAKE = 2;
  localparam logic [N*N-1:0] DEP = 100'h60;
  typedef struct packed {
    logic [N-1:0] pwr_on;
    logic [N-1:0] iso;
    logic [N-1:0] sleep;
    logic         busy;
  } out_t;
  typedef enum int {AWAKE, CLAMPING, ASLEEP, RESTORING, SETTLING} mode_t;
  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         gate = 1'b1;
  logic [N-1:0] sensor = '0;
  logic [N-1:0] ok = '0;
  logic [N-1:0] pwr_on, iso, sleep;
  logic         busy;
  out_t         exp_q[$];
  mode_t        mode[N];
  int           streak[N];
  int           leave_at[N];
  int           edge_n = 0;
  int           tests = 0;
  int           fails = 0;
  sleep_gate_fsm_ctrl #(.N_CH(N), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8), .DEP_MASK(DEP)) dut (
    .clk_i(clk), .nrst_i(nrst), .gate_en_i(gate), .sensor_i(sensor), .pwr_ok_i(ok),
    .pwr_on_o(pwr_on), .iso_o(iso), .sleep_o(sleep), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic model_step();
    logic [N-1:0] idl;
    logic         deps;
    out_t         e;
    edge_n++;
    for (int i = 0; i < N; i++)
      idl[i] = (mode[i] == AWAKE && streak[i] >= IDLE) || mode[i] == CLAMPING || mode[i] == ASLEEP;
    for (int i = 0; i < N; i++) begin
      if (!nrst) begin
        mode[i]   = AWAKE;
        streak[i] = 0;
      end else begin
        case (mode[i])
          AWAKE: begin
            deps = 1'b1;
            for (int j = 0; j < N; j++) if (DEP[i*N+j] && !idl[j]) deps = 1'b0;
            streak[i] = (sensor[i] && gate) ? streak[i] + 1 : 0;
            if (gate && idl[i] && deps) begin
              mode[i]   = CLAMPING;
              streak[i] = 0;
            end
          end
          CLAMPING: mode[i] = ASLEEP;
          ASLEEP:   if (!sensor[i] || !gate) mode[i] = RESTORING;
          RESTORING: if (ok[i]) begin
            mode[i]     = SETTLING;
            leave_at[i] = edge_n + WAKE;
          end
          SETTLING: if (edge_n == leave_at[i]) begin
            mode[i]   = AWAKE;
            streak[i] = 0;
          end
          default: mode[i] = AWAKE;
        endcase
      end
    end
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.pwr_on[i] = mode[i] != ASLEEP;
      e.iso[i]    = mode[i] != AWAKE;
      e.sleep[i]  = mode[i] == ASLEEP;
      e.busy      = e.busy | (mode[i] == CLAMPING || mode[i] == RESTORING || mode[i] == SETTLING);
    end
    exp_q.push_back(e);
  endtask
  task automatic apply(input logic [N-1:0] s, input logic g, input logic [N-1:0] k, input logic rn, input int n);
    repeat (n) begin
      @(negedge clk);
      sensor = s;
      gate   = g;
      ok     = k;
      nrst   = rn;
      model_step();
    end
  endtask
  initial begin
    out_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {pwr_on, iso, sleep, busy};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs edge %0d: got pwr_on=%b iso=%b sleep=%b busy=%b, expected pwr_on=%b iso=%b sleep=%b busy=%b",
                   edge_n, got.pwr_on, got.iso, got.sleep, got.busy, e.pwr_on, e.iso, e.sleep, e.busy);
        end
      end
    end
  end
  initial begin
    logic [N-1:0] s, k;
    logic         g, rn;
    for (int i = 0; i < N; i++) begin
      mode[i]     = AWAKE;
      streak[i]   = 0;
      leave_at[i] = 0;
    end
    apply('0, 1'b1, '0, 1'b0, 2);
    apply(10'h008, 1'b1, '0, 1'b1, 8);
    apply('0, 1'b1, '0, 1'b1, 3);
    apply('0, 1'b1, 10'h008, 1'b1, 4);
    apply(10'h008, 1'b1, '0, 1'b1, 3);
    apply('0, 1'b1, '0, 1'b1, 1);
    apply(10'h008, 1'b1, '0, 1'b1, 7);
    apply('0, 1'b1, '1, 1'b1, 5);
    apply(10'h001, 1'b1, '0, 1'b1, 6);
    apply(10'h021, 1'b1, '0, 1'b1, 3);
    apply(10'h061, 1'b1, '0, 1'b1, 8);
    apply('0, 1'b1, '1, 1'b1, 6);
    apply(10'h004, 1'b1, '0, 1'b1, 7);
    apply('1, 1'b0, '0, 1'b1, 2);
    apply('1, 1'b0, '1, 1'b1, 6);
    apply('0, 1'b1, '0, 1'b1, 2);
    apply(10'h002, 1'b1, '0, 1'b1, 7);
    apply('0, 1'b1, '0, 1'b1, 1);
    apply('0, 1'b1, '0, 1'b0, 1);
    apply('0, 1'b1, '0, 1'b1, 3);
    s = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 6) == 0) s[i] = ~s[i];
      for (int i = 0; i < N; i++) k[i] = $urandom_range(0, 2) == 0;
      g  = $urandom_range(0, 19) != 0;
      rn = $urandom_range(0, 199) != 0;
      apply(s, g, k, rn, 1);
    end
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
